uart_io_bridge: RTL and testbench

- CPU-side stage directly upstream/downstream of the UART AXI-lite controller's byte streams.
- Converts CPU out/in requests (byte or 32-bit word) into per-byte AXI4-stream traffic and back.
- Buffers each direction in its own FIFO so the core does not stall on UART latency.
- TX path feeds the controller's UART_WRITE_T* slave; RX path consumes its UART_READ_T* master.

---
 rtl/uart_io_pkg.sv | 15 +
 rtl/byte_fifo.sv | 57 +++++
 rtl/uart_io_bridge.sv | 149 ++++++++++++++
 tb/tb_uart_io_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared constants and RX FSM encoding for the CPU <-> UART byte-stream bridge.
package uart_io_pkg;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } rx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous fall-through byte FIFO with exact occupancy count and registered flags.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  // A push is refused while full even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + CNT_W'(1);
    else if (do_pop && !do_push) count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_io_bridge.sv
// CPU byte/word requests to per-byte AXI4-stream traffic and back, buffered by one FIFO per direction.
module uart_io_bridge
  import uart_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_out_valid,
  output logic             cpu_out_ready,
  input  logic             cpu_out_size,
  input  logic [31:0]      cpu_out_data,
  input  logic             cpu_in_valid,
  output logic             cpu_in_ready,
  input  logic             cpu_in_size,
  output logic             cpu_in_done,
  output logic [31:0]      cpu_in_data,
  output logic [7:0]       tx_tdata,
  output logic             tx_tvalid,
  input  logic             tx_tready,
  input  logic [7:0]       rx_tdata,
  input  logic             rx_tvalid,
  output logic             rx_tready,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [1:0]       rx_state
);

  // Handshakes: every stream/request transfers on the rising edge where valid && ready are both high.

  logic [2:0]  tx_rem;
  logic [31:0] tx_shift;
  logic        tx_push;
  logic        tx_full;
  logic        tx_empty;

  assign cpu_out_ready = (tx_rem == 3'd0);
  assign tx_push       = (tx_rem != 3'd0) && !tx_full;
  assign tx_tvalid     = !tx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_rem   <= 3'd0;
      tx_shift <= '0;
    end else if (cpu_out_valid && cpu_out_ready) begin
      tx_shift <= cpu_out_data;
      tx_rem   <= (cpu_out_size == SIZE_WORD) ? 3'(BYTES_PER_WORD) : 3'd1;
    end else if (tx_push) begin
      tx_shift <= tx_shift >> 8;
      tx_rem   <= tx_rem - 3'd1;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_shift[7:0]),
    .pop       (tx_tvalid && tx_tready),
    .head      (tx_tdata),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  logic        rx_full;
  logic        rx_empty;
  logic        rx_pop;
  logic        last_pop;
  logic [7:0]  rx_head;
  logic [2:0]  need_q;
  logic [1:0]  idx_q;
  logic [31:0] asm_q;
  logic [31:0] assembled;
  rx_state_e   state_q;
  rx_state_e   state_d;

  assign rx_tready = !rx_full;
  assign rx_state  = state_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_tvalid && rx_tready),
    .push_data (rx_tdata),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_comb begin
    assembled = asm_q;
    assembled[8*idx_q +: 8] = rx_head;
  end

  always_comb begin
    state_d      = state_q;
    cpu_in_ready = 1'b0;
    cpu_in_done  = 1'b0;
    rx_pop       = 1'b0;
    last_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_in_ready = 1'b1;
        if (cpu_in_valid) state_d = COLLECT;
      end
      COLLECT: begin
        if (!rx_empty) begin
          rx_pop = 1'b1;
          if ({1'b0, idx_q} == need_q - 3'd1) begin
            last_pop = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        cpu_in_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      need_q      <= 3'd0;
      idx_q       <= 2'd0;
      asm_q       <= '0;
      cpu_in_data <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cpu_in_valid) begin
        asm_q  <= '0;
        need_q <= (cpu_in_size == SIZE_WORD) ? 3'(BYTES_PER_WORD) : 3'd1;
        idx_q  <= 2'd0;
      end else if (rx_pop) begin
        asm_q <= assembled;
        idx_q <= idx_q + 2'd1;
      end
      // Result is published on the final pop so it is valid throughout DONE.
      if (last_pop) cpu_in_data <= assembled;
    end
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Bench for uart_io_bridge: table-driven TX/RX vectors plus hand sequences for stall, full and reset cases.
module tb_uart_io_bridge;
  import uart_io_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             cpu_out_valid;
  logic             cpu_out_ready;
  logic             cpu_out_size;
  logic [31:0]      cpu_out_data;
  logic             cpu_in_valid;
  logic             cpu_in_ready;
  logic             cpu_in_size;
  logic             cpu_in_done;
  logic [31:0]      cpu_in_data;
  logic [7:0]       tx_tdata;
  logic             tx_tvalid;
  logic             tx_tready;
  logic [7:0]       rx_tdata;
  logic             rx_tvalid;
  logic             rx_tready;
  logic [CNT_W-1:0] tx_count;
  logic [CNT_W-1:0] rx_count;
  logic [1:0]       rx_state;

  uart_io_bridge #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_out_valid (cpu_out_valid),
    .cpu_out_ready (cpu_out_ready),
    .cpu_out_size  (cpu_out_size),
    .cpu_out_data  (cpu_out_data),
    .cpu_in_valid  (cpu_in_valid),
    .cpu_in_ready  (cpu_in_ready),
    .cpu_in_size   (cpu_in_size),
    .cpu_in_done   (cpu_in_done),
    .cpu_in_data   (cpu_in_data),
    .tx_tdata      (tx_tdata),
    .tx_tvalid     (tx_tvalid),
    .tx_tready     (tx_tready),
    .rx_tdata      (rx_tdata),
    .rx_tvalid     (rx_tvalid),
    .rx_tready     (rx_tready),
    .tx_count      (tx_count),
    .rx_count      (rx_count),
    .rx_state      (rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_seen = 0;
  int tr_mode = 0;
  int cyc     = 0;
  logic prev_done = 1'b0;

  logic [7:0]  exp_q[$];
  logic [31:0] exp_rx_q[$];

  typedef struct {
    logic        size;
    logic [31:0] data;
    int          nbytes;
  } tx_vec_t;

  typedef struct {
    logic        size;
    int          nb;
    logic [31:0] stream;
    logic [31:0] exp;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // tready pattern: 0 always high, 1 one pulse every 3 cycles, 2 held low
  always @(posedge clk) begin
    #1;
    cyc++;
    case (tr_mode)
      0:       tx_tready = 1'b1;
      1:       tx_tready = (cyc % 3 == 0);
      default: tx_tready = 1'b0;
    endcase
  end

  // scoreboard monitor, mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_tvalid && tx_tready) begin
        tx_seen++;
        if (exp_q.size() == 0) check("tx_unexpected_byte", {24'd0, tx_tdata}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, tx_tdata}, {24'd0, exp_q.pop_front()});
      end
      if (cpu_in_done) begin
        check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (exp_rx_q.size() == 0) check("rx_unexpected_done", cpu_in_data, 32'hFFFF_FFFF);
        else check("rx_word", cpu_in_data, exp_rx_q.pop_front());
      end
      prev_done = cpu_in_done;
    end
  end

  // driver tasks
  task automatic cpu_write(input logic size, input logic [31:0] data);
    int n;
    logic [31:0] d;
    @(posedge clk); #1;
    cpu_out_valid = 1'b1;
    cpu_out_size  = size;
    cpu_out_data  = data;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cpu_out_ready) break;
    end
    if (n == 200) check("cpu_write_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    cpu_out_valid = 1'b0;
    d = data;
    for (int i = 0; i < ((size == SIZE_WORD) ? 4 : 1); i++) begin
      exp_q.push_back(d[7:0]);
      d = d >> 8;
    end
  endtask

  task automatic cpu_read(input logic size, input logic [31:0] exp, input bit track);
    int n;
    @(posedge clk); #1;
    cpu_in_valid = 1'b1;
    cpu_in_size  = size;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cpu_in_ready) break;
    end
    if (n == 200) check("cpu_read_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    cpu_in_valid = 1'b0;
    if (track) exp_rx_q.push_back(exp);
  endtask

  task automatic push_rx(input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    rx_tvalid = 1'b1;
    rx_tdata  = b;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rx_tready) break;
    end
    if (n == 200) check("push_rx_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
  endtask

  // cycles (negedges after the last accept edge) until sig goes high; 99 on timeout
  task automatic cycles_until_out_ready(output int k);
    for (k = 1; k < 50; k++) begin
      @(negedge clk);
      if (cpu_out_ready) return;
    end
    k = 99;
  endtask

  task automatic cycles_until_done(output int k);
    for (k = 1; k < 200; k++) begin
      @(negedge clk);
      if (cpu_in_done) return;
    end
    k = 99;
  endtask

  task automatic drain_tx(input string name);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_count == '0 && cpu_out_ready) break;
    end
    check(name, 32'(tx_count), 32'd0);
  endtask

  function automatic logic [7:0] fill_val(input int i);
    return 8'(i * 17 + 3);
  endfunction

  initial begin
    int k;
    int seen0;
    int ready_seen;
    int stalled_done;

    tx_tab[0] = '{SIZE_BYTE, 32'h0000_00A5, 1};
    tx_tab[1] = '{SIZE_WORD, 32'h1122_3344, 4};
    tx_tab[2] = '{SIZE_BYTE, 32'hFFFF_FF3C, 1};
    tx_tab[3] = '{SIZE_WORD, 32'hDEAD_BEEF, 4};
    rx_tab[0] = '{SIZE_WORD, 4, 32'hEFBE_ADDE, 32'hDEAD_BEEF};
    rx_tab[1] = '{SIZE_BYTE, 1, 32'h7F00_0000, 32'h0000_007F};
    rx_tab[2] = '{SIZE_WORD, 4, 32'h0102_0304, 32'h0403_0201};
    rx_tab[3] = '{SIZE_BYTE, 1, 32'hFF00_0000, 32'h0000_00FF};

    rst = 1'b1;
    cpu_out_valid = 1'b0; cpu_out_size = 1'b0; cpu_out_data = '0;
    cpu_in_valid  = 1'b0; cpu_in_size  = 1'b0;
    rx_tvalid = 1'b0; rx_tdata = '0; tx_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_out_ready", {31'd0, cpu_out_ready}, 32'd1);
    check("rst_cpu_in_ready", {31'd0, cpu_in_ready}, 32'd1);
    check("rst_cpu_in_done", {31'd0, cpu_in_done}, 32'd0);
    check("rst_cpu_in_data", cpu_in_data, 32'd0);
    check("rst_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
    check("rst_rx_tready", {31'd0, rx_tready}, 32'd1);
    check("rst_counts", {16'(tx_count), 16'(rx_count)}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // TX vectors with pulsed tready
    tr_mode = 1;
    for (int i = 0; i < 4; i++) begin
      seen0 = tx_seen;
      cpu_write(tx_tab[i].size, tx_tab[i].data);
      cycles_until_out_ready(k);
      check("tx_ready_low_cycles", 32'(k - 1), 32'(tx_tab[i].nbytes));
      drain_tx("tx_count_drained");
      repeat (3) @(negedge clk);
      check("tx_bytes_sent", 32'(tx_seen - seen0), 32'(tx_tab[i].nbytes));
      check("tx_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // TX backpressure: 5 words into a 16-deep FIFO with tready held low
    tr_mode = 2;
    seen0 = tx_seen;
    for (int i = 0; i < 5; i++) cpu_write(SIZE_WORD, 32'h0302_0100 + 32'h0404_0404 * 32'(i));
    ready_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (cpu_out_ready) ready_seen++;
    end
    check("tx_full_ready_held_low", 32'(ready_seen), 32'd0);
    check("tx_full_count", 32'(tx_count), 32'd16);
    check("tx_full_tvalid", {31'd0, tx_tvalid}, 32'd1);
    tr_mode = 0;
    drain_tx("tx_full_drained");
    repeat (3) @(negedge clk);
    check("tx_full_bytes_sent", 32'(tx_seen - seen0), 32'd20);

    // RX vectors with data already buffered
    for (int i = 0; i < 4; i++) begin
      logic [31:0] s;
      s = rx_tab[i].stream;
      for (int j = 0; j < rx_tab[i].nb; j++) begin
        push_rx(s[31:24]);
        s = s << 8;
      end
      @(negedge clk);
      check("rx_count_buffered", 32'(rx_count), 32'(rx_tab[i].nb));
      cpu_read(rx_tab[i].size, rx_tab[i].exp, 1'b1);
      cycles_until_done(k);
      check("rx_done_latency", 32'(k), 32'(rx_tab[i].nb + 1));
      @(negedge clk);
      check("rx_count_after_read", 32'(rx_count), 32'd0);
      check("rx_state_idle", {30'd0, rx_state}, {30'd0, IDLE});
    end

    // Word read stalls in COLLECT with only 2 bytes buffered
    push_rx(8'hA1);
    push_rx(8'hB2);
    cpu_read(SIZE_WORD, 32'hD4C3_B2A1, 1'b1);
    stalled_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_in_done) stalled_done++;
    end
    check("stall_no_done", 32'(stalled_done), 32'd0);
    check("stall_state_collect", {30'd0, rx_state}, {30'd0, COLLECT});
    check("stall_rx_count", 32'(rx_count), 32'd0);
    push_rx(8'hC3);
    push_rx(8'hD4);
    cycles_until_done(k);
    check("stall_done_latency", 32'(k), 32'd2);

    // RX FIFO full: tready drops and extra bytes are held off
    for (int i = 0; i < 16; i++) push_rx(fill_val(i));
    @(negedge clk);
    check("rx_full_tready", {31'd0, rx_tready}, 32'd0);
    @(posedge clk); #1;
    rx_tvalid = 1'b1;
    rx_tdata  = 8'hEE;
    repeat (5) @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
    @(negedge clk);
    check("rx_full_count", 32'(rx_count), 32'd16);
    for (int w = 0; w < 4; w++) begin
      cpu_read(SIZE_WORD, {fill_val(4*w+3), fill_val(4*w+2), fill_val(4*w+1), fill_val(4*w)}, 1'b1);
      cycles_until_done(k);
      check("rx_full_read_latency", 32'(k), 32'd5);
    end

    // Reset in COLLECT after 2 of 4 bytes, with TX bytes pending
    tr_mode = 2;
    cpu_write(SIZE_WORD, 32'hCAFE_F00D);
    push_rx(8'h11);
    push_rx(8'h22);
    cpu_read(SIZE_WORD, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_state_collect", {30'd0, rx_state}, {30'd0, COLLECT});
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_cpu_out_ready", {31'd0, cpu_out_ready}, 32'd1);
    check("mid_rst_cpu_in_ready", {31'd0, cpu_in_ready}, 32'd1);
    check("mid_rst_cpu_in_data", cpu_in_data, 32'd0);
    check("mid_rst_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
    check("mid_rst_rx_tready", {31'd0, rx_tready}, 32'd1);
    check("mid_rst_counts", {16'(tx_count), 16'(rx_count)}, 32'd0);
    check("mid_rst_state", {30'd0, rx_state}, {30'd0, IDLE});
    @(posedge clk); #1;
    rst = 1'b0;
    tr_mode = 0;
    push_rx(8'h5A);
    cpu_read(SIZE_BYTE, 32'h0000_005A, 1'b1);
    cycles_until_done(k);
    check("post_rst_done_latency", 32'(k), 32'd2);

    repeat (5) @(negedge clk);
    check("final_tx_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_rx_queue_empty", 32'(exp_rx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
